// File: rtl/wb_stage_reg.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// wb_stage_reg
// MEM/WB pipeline register fused with the writeback source selector.
// Captures the MEM-stage bundle, extracts and extends load data by size and
// byte offset, picks one of four writeback sources and drives the register-file
// write port. Also flags misaligned loads and counts retired instructions.
//
// Ports
//   i_clk, i_reset       clock (rising edge), asynchronous active-high reset
//   i_stall, i_flush     hold register / insert bubble (flush wins)
//   i_valid              MEM bundle holds a real instruction
//   i_pc_four            PC+4 of MEM instruction
//   i_alu_data           ALU result; low bits give load byte offset
//   i_ld_data            raw aligned memory word
//   i_csr_data           CSR read data
//   i_wb_sel             00 ALU, 01 load, 10 PC+4, 11 CSR
//   i_ld_funct3          RISC-V load funct3
//   i_rd_addr, i_rd_wen  destination register and its write request
//   o_wb_valid           WB stage holds a real instruction
//   o_rd_addr            registered destination register
//   o_rd_wen             register-file write enable
//   o_wb_data            register-file write data
//   o_ld_misalign        WB load is misaligned
//   o_instret            retired-instruction counter
// -----------------------------------------------------------------------------
module wb_stage_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_pc_four,
    input  logic [DATA_W-1:0]  i_alu_data,
    input  logic [DATA_W-1:0]  i_ld_data,
    input  logic [DATA_W-1:0]  i_csr_data,
    input  logic [1:0]         i_wb_sel,
    input  logic [2:0]         i_ld_funct3,
    input  logic [RADDR_W-1:0] i_rd_addr,
    input  logic               i_rd_wen,
    output logic               o_wb_valid,
    output logic [RADDR_W-1:0] o_rd_addr,
    output logic               o_rd_wen,
    output logic [DATA_W-1:0]  o_wb_data,
    output logic               o_ld_misalign,
    output logic [CNT_W-1:0]   o_instret
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    logic               r_valid;
    logic [DATA_W-1:0]  r_pc_four;
    logic [DATA_W-1:0]  r_alu_data;
    logic [DATA_W-1:0]  r_ld_data;
    logic [DATA_W-1:0]  r_csr_data;
    logic [1:0]         r_wb_sel;
    logic [2:0]         r_ld_funct3;
    logic [RADDR_W-1:0] r_rd_addr;
    logic               r_rd_wen;
    logic [CNT_W-1:0]   r_instret;

    // ------------------------------------------------------------------
    // Pipeline register and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid     <= 1'b0;
            r_pc_four   <= '0;
            r_alu_data  <= '0;
            r_ld_data   <= '0;
            r_csr_data  <= '0;
            r_wb_sel    <= '0;
            r_ld_funct3 <= '0;
            r_rd_addr   <= '0;
            r_rd_wen    <= 1'b0;
            r_instret   <= '0;
        end else begin
            // The WB instruction retires on the edge it leaves the stage.
            if (r_valid && (i_flush || !i_stall)) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (i_flush) begin
                // Only valid matters for a bubble; outputs are gated by it.
                r_valid <= 1'b0;
            end else if (!i_stall) begin
                r_valid     <= i_valid;
                r_pc_four   <= i_pc_four;
                r_alu_data  <= i_alu_data;
                r_ld_data   <= i_ld_data;
                r_csr_data  <= i_csr_data;
                r_wb_sel    <= i_wb_sel;
                r_ld_funct3 <= i_ld_funct3;
                r_rd_addr   <= i_rd_addr;
                r_rd_wen    <= i_rd_wen;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load size decode
    // ------------------------------------------------------------------
    logic [1:0] w_size;
    logic       w_unsigned;

    always_comb begin
        w_size     = SZ_W;
        w_unsigned = 1'b0;
        unique case (r_ld_funct3)
            3'b000: w_size = SZ_B;
            3'b001: w_size = SZ_H;
            3'b010: w_size = SZ_W;
            3'b011: w_size = (DATA_W == 64) ? SZ_D : SZ_W;
            3'b100: begin
                w_size     = SZ_B;
                w_unsigned = 1'b1;
            end
            3'b101: begin
                w_size     = SZ_H;
                w_unsigned = 1'b1;
            end
            3'b110: begin
                w_size     = SZ_W;
                w_unsigned = (DATA_W == 64);
            end
            default: w_size = SZ_W;
        endcase
    end

    // ------------------------------------------------------------------
    // Load extract: shift the addressed lane down, then mask and extend
    // ------------------------------------------------------------------
    logic [OFF_W-1:0]  w_off;
    logic [DATA_W-1:0] w_shifted;
    logic [6:0]        w_nbits;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_sign_mask;
    logic              w_sign;
    logic [DATA_W-1:0] w_ld_ext;
    logic [OFF_W-1:0]  w_align_mask;
    logic              w_misalign_raw;

    always_comb begin
        w_off     = r_alu_data[OFF_W-1:0];
        w_shifted = r_ld_data >> {w_off, 3'b000};
        w_nbits   = 7'd8 << w_size;
        // A shift by the full width yields zero, so a full-width access masks all ones.
        w_mask      = ~({DATA_W{1'b1}} << w_nbits);
        w_sign_mask = w_mask ^ (w_mask >> 1);
        w_sign      = |(w_shifted & w_sign_mask);
        w_ld_ext    = w_shifted & w_mask;
        if (!w_unsigned && w_sign) begin
            w_ld_ext = w_ld_ext | ~w_mask;
        end
        // Offset bits below the access size must be zero.
        w_align_mask   = OFF_W'((4'd1 << w_size) - 4'd1);
        w_misalign_raw = |(w_off & w_align_mask);
    end

    // ------------------------------------------------------------------
    // Writeback select and write-port drive
    // ------------------------------------------------------------------
    logic w_is_load;

    always_comb begin
        w_is_load     = (r_wb_sel == 2'b01);
        o_wb_valid    = r_valid;
        o_rd_addr     = r_rd_addr;
        o_ld_misalign = r_valid && w_is_load && w_misalign_raw;
        o_rd_wen      = r_valid && r_rd_wen && (r_rd_addr != '0) && !o_ld_misalign;
        o_instret     = r_instret;
        o_wb_data     = '0;
        if (r_valid) begin
            unique case (r_wb_sel)
                2'b00:   o_wb_data = r_alu_data;
                2'b01:   o_wb_data = o_ld_misalign ? '0 : w_ld_ext;
                2'b10:   o_wb_data = r_pc_four;
                default: o_wb_data = r_csr_data;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage_reg.sv
`timescale 1ns / 1ps
module tb_wb_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall, flush, valid, wen;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [63:0] pc, alu, ld, csr;
    logic [4:0]  rd;

    logic        a_valid, a_wen, a_mis;
    logic [4:0]  a_rd;
    logic [31:0] a_data, a_instret;
    logic        b_valid, b_wen, b_mis;
    logic [4:0]  b_rd;
    logic [63:0] b_data;
    logic [2:0]  b_instret;

    wb_stage_reg #(.DATA_W(32), .RADDR_W(5), .CNT_W(32)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_pc_four(pc[31:0]), .i_alu_data(alu[31:0]), .i_ld_data(ld[31:0]),
        .i_csr_data(csr[31:0]), .i_wb_sel(sel), .i_ld_funct3(f3), .i_rd_addr(rd),
        .i_rd_wen(wen), .o_wb_valid(a_valid), .o_rd_addr(a_rd), .o_rd_wen(a_wen),
        .o_wb_data(a_data), .o_ld_misalign(a_mis), .o_instret(a_instret)
    );

    // Narrow counter on the 64-bit instance exercises wrap-around.
    wb_stage_reg #(.DATA_W(64), .RADDR_W(5), .CNT_W(3)) dut64 (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_pc_four(pc), .i_alu_data(alu), .i_ld_data(ld), .i_csr_data(csr),
        .i_wb_sel(sel), .i_ld_funct3(f3), .i_rd_addr(rd), .i_rd_wen(wen),
        .o_wb_valid(b_valid), .o_rd_addr(b_rd), .o_rd_wen(b_wen),
        .o_wb_data(b_data), .o_ld_misalign(b_mis), .o_instret(b_instret)
    );

    typedef struct {
        int          id;
        logic        stall, flush, valid;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [63:0] pc, alu, ld, csr;
        logic [4:0]  rd;
        logic        wen;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic        e_wen;
        logic [31:0] e_data;
        logic        e_mis;
        logic        chk64;
        logic [63:0] e_data64;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_cnt;
    logic        m_valid;
    vec_t        sb[$];
    vec_t        tbl[13];

    function automatic vec_t mk(input int id, input logic st, input logic fl, input logic va,
                                input logic [1:0] s, input logic [2:0] f,
                                input logic [63:0] p, input logic [63:0] a,
                                input logic [63:0] l, input logic [63:0] c,
                                input logic [4:0] r, input logic w, input logic ev,
                                input logic [4:0] er, input logic ew,
                                input logic [31:0] ed, input logic em);
        vec_t v;
        v.id = id; v.stall = st; v.flush = fl; v.valid = va; v.sel = s; v.f3 = f;
        v.pc = p; v.alu = a; v.ld = l; v.csr = c; v.rd = r; v.wen = w;
        v.e_valid = ev; v.e_rd = er; v.e_wen = ew; v.e_data = ed; v.e_mis = em;
        v.chk64 = 1'b0; v.e_data64 = '0;
        return v;
    endfunction

    task automatic check(input int id, input string what, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%0h, expected 0x%0h", id, what, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        stall = v.stall; flush = v.flush; valid = v.valid; sel = v.sel; f3 = v.f3;
        pc = v.pc; alu = v.alu; ld = v.ld; csr = v.csr; rd = v.rd; wen = v.wen;
        sb.push_back(v);
        // Retire model: the WB instruction leaves on this edge unless held.
        if (m_valid && (v.flush || !v.stall)) m_cnt = m_cnt + 32'd1;
        if (v.flush) m_valid = 1'b0;
        else if (!v.stall) m_valid = v.valid;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check(v.id, "scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check(e.id, "wb_valid", 64'(a_valid), 64'(e.e_valid));
            if (e.e_valid) check(e.id, "rd_addr", 64'(a_rd), 64'(e.e_rd));
            check(e.id, "rd_wen", 64'(a_wen), 64'(e.e_wen));
            check(e.id, "wb_data", 64'(a_data), 64'(e.e_data));
            check(e.id, "ld_misalign", 64'(a_mis), 64'(e.e_mis));
            check(e.id, "instret", 64'(a_instret), 64'(m_cnt));
            check(e.id, "instret64_wrap", 64'(b_instret), 64'(m_cnt[2:0]));
            if (e.chk64) check(e.id, "wb_data64", b_data, e.e_data64);
        end
    endtask

    task automatic check_all_zero(input int id);
        check(id, "rst_valid", 64'(a_valid), 64'd0);
        check(id, "rst_rd_wen", 64'(a_wen), 64'd0);
        check(id, "rst_data", 64'(a_data), 64'd0);
        check(id, "rst_mis", 64'(a_mis), 64'd0);
        check(id, "rst_instret", 64'(a_instret), 64'd0);
        check(id, "rst_valid64", 64'(b_valid), 64'd0);
        check(id, "rst_data64", b_data, 64'd0);
        check(id, "rst_instret64", 64'(b_instret), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        rst = 1'b1; stall = 0; flush = 0; valid = 0; wen = 0; sel = 0; f3 = 0;
        pc = 0; alu = 0; ld = 0; csr = 0; rd = 0;
        m_cnt = 0; m_valid = 0;

        //           id st fl va sel    f3      pc      alu           ld            csr  rd wen ev er ew data           mis
        tbl[0]  = mk(1, 0, 0, 1, 2'b01, 3'b000, 64'h0, 64'h1003,     64'h80FF_0000, 64'h0, 5, 1, 1, 5, 1, 32'hFFFF_FF80, 0);
        tbl[1]  = mk(2, 0, 0, 1, 2'b01, 3'b101, 64'h0, 64'h2002,     64'hBEEF_1234, 64'h0, 5, 1, 1, 5, 1, 32'h0000_BEEF, 0);
        tbl[2]  = mk(3, 0, 0, 1, 2'b01, 3'b010, 64'h0, 64'h2002,     64'hBEEF_1234, 64'h0, 5, 1, 1, 5, 0, 32'h0,         1);
        tbl[3]  = mk(4, 0, 0, 1, 2'b11, 3'b000, 64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF,        0, 1, 1, 0, 0, 32'hDEAD_BEEF, 0);
        tbl[4]  = mk(5, 0, 0, 1, 2'b00, 3'b000, 64'h0, 64'h1234_5678, 64'h0,        64'h0, 3, 1, 1, 3, 1, 32'h1234_5678, 0);
        tbl[5]  = mk(6, 0, 0, 1, 2'b01, 3'b001, 64'h0, 64'h1001,     64'h8001_0000, 64'h0, 7, 1, 1, 7, 0, 32'h0,         1);
        tbl[6]  = mk(7, 0, 0, 1, 2'b01, 3'b001, 64'h0, 64'h1002,     64'h8001_0000, 64'h0, 7, 1, 1, 7, 1, 32'hFFFF_8001, 0);
        tbl[7]  = mk(8, 0, 0, 1, 2'b01, 3'b100, 64'h0, 64'h1001,     64'h0000_F000, 64'h0, 8, 1, 1, 8, 1, 32'h0000_00F0, 0);
        tbl[8]  = mk(9, 0, 0, 0, 2'b00, 3'b000, 64'h0, 64'h55,       64'h0,         64'h0, 3, 1, 0, 3, 0, 32'h0,         0);
        tbl[9]  = mk(10, 0, 0, 1, 2'b01, 3'b111, 64'h0, 64'h100,     64'hCAFE_F00D, 64'h0, 9, 1, 1, 9, 1, 32'hCAFE_F00D, 0);
        tbl[10] = mk(11, 0, 0, 1, 2'b01, 3'b011, 64'h0, 64'h4,       64'h8765_4321, 64'h0, 9, 1, 1, 9, 1, 32'h8765_4321, 0);
        tbl[11] = mk(12, 0, 0, 1, 2'b01, 3'b110, 64'h0, 64'h3,       64'h8765_4321, 64'h0, 9, 1, 1, 9, 0, 32'h0,         1);
        tbl[12] = mk(13, 0, 0, 1, 2'b10, 3'b000, 64'h200, 64'h0,     64'h0,         64'h0, 7, 0, 1, 7, 0, 32'h0000_0200, 0);

        #1;
        check_all_zero(0);
        #11 rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(tbl[i]);

        // Stall holds the WB instruction; it retires once when the stall drops.
        run_vec(mk(20, 0, 0, 1, 2'b10, 3'b000, 64'h104, 64'h0, 64'h0, 64'h0, 1, 1, 1, 1, 1, 32'h104, 0));
        for (int i = 0; i < 3; i++)
            run_vec(mk(21 + i, 1, 0, 1, 2'b00, 3'b000, 64'h0, 64'hFFFF, 64'h0, 64'h0, 2, 1,
                       1, 1, 1, 32'h104, 0));
        run_vec(mk(24, 0, 0, 0, 2'b00, 3'b000, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 32'h0, 0));

        // Flush with and without a simultaneous stall.
        run_vec(mk(30, 0, 0, 1, 2'b00, 3'b000, 64'h0, 64'h77, 64'h0, 64'h0, 4, 1, 1, 4, 1, 32'h77, 0));
        run_vec(mk(31, 1, 1, 1, 2'b00, 3'b000, 64'h0, 64'h99, 64'h0, 64'h0, 6, 1, 0, 0, 0, 32'h0, 0));
        run_vec(mk(32, 0, 0, 1, 2'b11, 3'b000, 64'h0, 64'h0, 64'h0, 64'h5A5A, 8, 1, 1, 8, 1, 32'h5A5A, 0));
        run_vec(mk(33, 0, 1, 1, 2'b00, 3'b000, 64'h0, 64'h11, 64'h0, 64'h0, 6, 1, 0, 0, 0, 32'h0, 0));

        // 64-bit loads; the 32-bit instance sees the low word at offset 0.
        v = mk(40, 0, 0, 1, 2'b01, 3'b011, 64'h0, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0, 9, 1,
               1, 9, 1, 32'h89AB_CDEF, 0);
        v.chk64 = 1'b1; v.e_data64 = 64'h0123_4567_89AB_CDEF;
        run_vec(v);
        v = mk(41, 0, 0, 1, 2'b01, 3'b010, 64'h0, 64'hC, 64'h0123_4567_89AB_CDEF, 64'h0, 9, 1,
               1, 9, 1, 32'h89AB_CDEF, 0);
        v.chk64 = 1'b1; v.e_data64 = 64'h0000_0000_0123_4567;
        run_vec(v);
        v = mk(42, 0, 0, 1, 2'b01, 3'b011, 64'h0, 64'hC, 64'h0123_4567_89AB_CDEF, 64'h0, 9, 1,
               1, 9, 1, 32'h89AB_CDEF, 0);
        v.chk64 = 1'b1; v.e_data64 = 64'h0;
        run_vec(v);

        // Asynchronous reset mid-cycle clears everything before the next edge.
        #2 rst = 1'b1;
        #1;
        m_cnt = 0; m_valid = 0;
        check_all_zero(50);
        @(posedge clk);
        #1;
        check_all_zero(51);
        #3 rst = 1'b0;

        run_vec(mk(60, 0, 0, 1, 2'b00, 3'b000, 64'h0, 64'h9, 64'h0, 64'h0, 2, 1, 1, 2, 1, 32'h9, 0));
        run_vec(mk(61, 0, 0, 0, 2'b00, 3'b000, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 32'h0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
